// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral mapping {rw, addr, data} frames onto a flat bank of control registers.
// Optional read-back over CIPO is built only when SPI_READBACK_EN is defined.
module spi_reg_bank #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_pulse,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int HDR_W   = 1 + ADDR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    // Bit 0 is the metastability stage, bit 1 the synchronised sample, bit 2 the previous sample.
    logic [2:0] sclk_sync_reg;
    logic [2:0] ncs_sync_reg;
    logic [1:0] copi_sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_reg <= '0;
            ncs_sync_reg  <= '1;
            copi_sync_reg <= '0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[1:0], sclk};
            ncs_sync_reg  <= {ncs_sync_reg[1:0], ncs};
            copi_sync_reg <= {copi_sync_reg[0], copi};
        end
    end

    logic sclk_rise;
    logic ncs_s;
    logic ncs_fall;
    logic ncs_rise;

    assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
    assign ncs_s     = ncs_sync_reg[1];
    assign ncs_fall  = ~ncs_sync_reg[1] & ncs_sync_reg[2];
    assign ncs_rise  = ncs_sync_reg[1] & ~ncs_sync_reg[2];

    logic [1:0]         state_reg;
    logic [FRAME_W-1:0] shift_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               wr_pulse_reg;
    logic [ADDR_W-1:0]  wr_addr_reg;
    logic               frame_err_reg;

    logic              fr_rw;
    logic [ADDR_W-1:0] fr_addr;
    logic [DATA_W-1:0] fr_data;
    logic              fr_full;
    logic              fr_addr_ok;

    assign fr_rw      = shift_reg[FRAME_W-1];
    assign fr_addr    = shift_reg[DATA_W +: ADDR_W];
    assign fr_data    = shift_reg[DATA_W-1:0];
    assign fr_full    = (count_reg == CNT_W'(FRAME_W));
    assign fr_addr_ok = ({1'b0, fr_addr} < NUM_REGS_L);

    // The commit decision is taken on the ncs rise so the strobe lines up with the COMMIT cycle,
    // while the bank itself is written during COMMIT and shows the new value one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            shift_reg     <= '0;
            count_reg     <= '0;
            wr_pulse_reg  <= 1'b0;
            wr_addr_reg   <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            wr_pulse_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        state_reg <= ST_SHIFT;
                        shift_reg <= '0;
                        count_reg <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (ncs_rise) begin
                        state_reg <= ST_COMMIT;
                        if (!fr_full) begin
                            frame_err_reg <= 1'b1;
                        end else if (fr_rw && fr_addr_ok) begin
                            wr_pulse_reg <= 1'b1;
                            wr_addr_reg  <= fr_addr;
                        end
                    end else if (sclk_rise && !ncs_s) begin
                        if (count_reg < CNT_W'(FRAME_W)) begin
                            shift_reg <= {shift_reg[FRAME_W-2:0], copi_sync_reg[1]};
                        end
                        if (count_reg != CNT_W'(FRAME_W + 1)) begin
                            count_reg <= count_reg + CNT_W'(1);
                        end
                    end
                end
                ST_COMMIT: begin
                    state_reg <= ST_IDLE;
                    if (ncs_fall) begin
                        state_reg <= ST_SHIFT;
                        shift_reg <= '0;
                        count_reg <= '0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] bank [NUM_REGS];
`endif

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] value_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    value_reg <= '0;
                end else if (wr_pulse_reg && (wr_addr_reg == ADDR_W'(gi))) begin
                    value_reg <= fr_data;
                end
            end

            assign regs_flat[gi*DATA_W +: DATA_W] = value_reg;
`ifdef SPI_READBACK_EN
            assign bank[gi] = value_reg;
`endif
        end
    endgenerate

    assign wr_pulse  = wr_pulse_reg;
    assign wr_addr   = wr_addr_reg;
    assign frame_err = frame_err_reg;

`ifdef SPI_READBACK_EN
    localparam int TXC_W = $clog2(DATA_W + 1);

    logic              sclk_fall;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] tx_reg;
    logic [TXC_W-1:0]  tx_left_reg;
    logic              tx_loaded_reg;
    logic              cipo_reg;

    assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];

    // Once the header is in, its address sits in the low bits of the shift register.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (shift_reg[ADDR_W-1:0] == ADDR_W'(i)) begin
                rd_data = bank[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_reg        <= '0;
            tx_left_reg   <= '0;
            tx_loaded_reg <= 1'b0;
            cipo_reg      <= 1'b0;
        end else if (state_reg != ST_SHIFT) begin
            tx_left_reg   <= '0;
            tx_loaded_reg <= 1'b0;
            cipo_reg      <= 1'b0;
        end else if (!tx_loaded_reg && count_reg == CNT_W'(HDR_W) && !shift_reg[ADDR_W]) begin
            tx_reg        <= rd_data;
            tx_left_reg   <= TXC_W'(DATA_W);
            tx_loaded_reg <= 1'b1;
        end else if (sclk_fall) begin
            if (tx_left_reg != '0) begin
                cipo_reg    <= tx_reg[DATA_W-1];
                tx_reg      <= {tx_reg[DATA_W-2:0], 1'b0};
                tx_left_reg <= tx_left_reg - TXC_W'(1);
            end else begin
                cipo_reg <= 1'b0;
            end
        end
    end

    assign cipo    = cipo_reg;
    assign cipo_oe = ~ncs_s;
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule
